// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter.
// Enables the oscillator, lets it settle, then counts synchronized rising
// edges of ro_in over a fixed window of GATE_CYCLES clk cycles. The result
// (saturating edge count plus overflow flag) is published with a one-cycle
// done pulse. ro_in is fully asynchronous to clk.
module ro_freq_meter #(
    parameter int GATE_CYCLES   = 1000,
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             ro_in,
    output logic             ro_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    // One cycle counter serves both SETTLE and GATE, so size it for the longer.
    localparam int CYC_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);

    localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
    localparam logic [CYC_W-1:0] GATE_LAST   = CYC_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        GATE   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic             sync1;
    logic             sync2;
    logic             sync3;
    logic             edge_q;

    logic [CYC_W-1:0] cyc_cnt;
    logic [CYC_W-1:0] cyc_nxt;
    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] edge_nxt;
    logic             ovf_flag;
    logic             ovf_nxt;

    logic             ro_en_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             load_result;

    // Two-flop synchronizer, a third flop for edge detection, and a registered
    // rising-edge flag. Runs in every state so SETTLE can flush stale samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            sync3  <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            sync1  <= ro_in;
            sync2  <= sync1;
            sync3  <= sync2;
            edge_q <= sync2 & ~sync3;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, counter and output decode. stop beats both start and
    // completion, so an abort in the final gate cycle yields no done pulse.
    always_comb begin
        state_nxt   = state;
        cyc_nxt     = cyc_cnt;
        edge_nxt    = edge_cnt;
        ovf_nxt     = ovf_flag;
        ro_en_nxt   = ro_en;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        load_result = 1'b0;

        case (state)
            IDLE: begin
                ro_en_nxt = 1'b0;
                busy_nxt  = 1'b0;
                if (start && !stop) begin
                    state_nxt = SETTLE;
                    ro_en_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                    cyc_nxt   = '0;
                    edge_nxt  = '0;
                    ovf_nxt   = 1'b0;
                end
            end

            SETTLE: begin
                if (stop) begin
                    state_nxt = IDLE;
                    ro_en_nxt = 1'b0;
                    busy_nxt  = 1'b0;
                end else if (cyc_cnt == SETTLE_LAST) begin
                    state_nxt = GATE;
                    cyc_nxt   = '0;
                end else begin
                    cyc_nxt = cyc_cnt + 1'b1;
                end
            end

            GATE: begin
                if (stop) begin
                    state_nxt = IDLE;
                    ro_en_nxt = 1'b0;
                    busy_nxt  = 1'b0;
                end else begin
                    // Saturating count: an edge arriving at full scale is
                    // recorded only as overflow.
                    if (edge_q) begin
                        if (edge_cnt == CNT_MAX) begin
                            ovf_nxt = 1'b1;
                        end else begin
                            edge_nxt = edge_cnt + 1'b1;
                        end
                    end
                    if (cyc_cnt == GATE_LAST) begin
                        state_nxt   = IDLE;
                        ro_en_nxt   = 1'b0;
                        busy_nxt    = 1'b0;
                        done_nxt    = 1'b1;
                        load_result = 1'b1;
                    end else begin
                        cyc_nxt = cyc_cnt + 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
                ro_en_nxt = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // Working counters and registered control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt  <= '0;
            edge_cnt <= '0;
            ovf_flag <= 1'b0;
            ro_en    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            cyc_cnt  <= cyc_nxt;
            edge_cnt <= edge_nxt;
            ovf_flag <= ovf_nxt;
            ro_en    <= ro_en_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

    // Published result; includes the edge seen in the last gate cycle and
    // only changes on a completed measurement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (load_result) begin
            count    <= edge_nxt;
            overflow <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_ro_freq_meter.sv
// Bench for ro_freq_meter: a gated square-wave oscillator model drives ro_in,
// and a cycle-level reference model predicts busy/ro_en/done/count/overflow.
module tb_ro_freq_meter;

    localparam int G    = 1000;
    localparam int S    = 16;
    localparam int W    = 7;
    localparam int MAXC = (1 << W) - 1;
    localparam int RUN  = S + G + 1;
    localparam int HIST = 65536;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         stop;
    logic         ro_in;
    logic         ro_en;
    logic         busy;
    logic         done;
    logic [W-1:0] count;
    logic         overflow;

    ro_freq_meter #(
        .GATE_CYCLES  (G),
        .SETTLE_CYCLES(S),
        .CNT_W        (W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .ro_in   (ro_in),
        .ro_en   (ro_en),
        .busy    (busy),
        .done    (done),
        .count   (count),
        .overflow(overflow)
    );

    // ---------------- clock / cycle index ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // ---------------- oscillator + reference model ----------------
    bit ro_hist [0:HIST-1];
    int hi_len = 5;
    int lo_len = 5;
    int ph     = 0;

    bit m_busy    = 1'b0;
    bit m_done    = 1'b0;
    int m_t       = 0;
    int m_count   = 0;
    bit m_ovf     = 1'b0;
    int dut_dones = 0;

    // Rising edges of the recorded ro_in waveform for cycles lo..hi.
    function automatic int edges_between(input int lo, input int hi);
        int n = 0;
        for (int k = lo; k <= hi; k++) begin
            if (k >= 1 && k < HIST) begin
                if (ro_hist[k] && !ro_hist[k-1]) n++;
            end
        end
        return n;
    endfunction

    // Mid-cycle: drive the oscillator, then compare DUT outputs against the
    // model's view of this cycle, then advance the model with this cycle's inputs.
    // A rising ro_in first seen in cycle k is counted if cycle k+3 lies in the gate
    // window [T+S+1, T+S+G], i.e. k in [T+S-2, T+S+G-3].
    always @(negedge clk) begin
        int n;
        if (ph >= hi_len + lo_len) ph = 0;
        ro_in = ro_en && (ph < hi_len);
        ph = ph + 1;
        if (cyc < HIST) ro_hist[cyc] = ro_in;

        if (rst) begin
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_count = 0;
            m_ovf   = 1'b0;
        end

        check("busy", busy, m_busy);
        check("ro_en", ro_en, m_busy);
        check("done", done, m_done);
        check("count", count, m_count);
        check("overflow", overflow, m_ovf);
        if (done) dut_dones++;

        if (!rst) begin
            m_done = 1'b0;
            if (m_busy) begin
                if (stop) begin
                    m_busy = 1'b0;
                end else if (cyc == m_t + S + G) begin
                    n       = edges_between(m_t + S - 2, cyc - 3);
                    m_busy  = 1'b0;
                    m_done  = 1'b1;
                    m_count = (n > MAXC) ? MAXC : n;
                    m_ovf   = (n > MAXC);
                end
            end else if (start && !stop) begin
                m_busy = 1'b1;
                m_t    = cyc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(output int t);
        start = 1'b1;
        t     = cyc;
        next_cycle();
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int at);
        at = -1;
        for (int i = 0; i < bound; i++) begin
            next_cycle();
            if (done) begin
                at = cyc;
                break;
            end
        end
        check("done_seen", (at >= 0), 1);
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (!busy) break;
            next_cycle();
        end
        check("idle_reached", busy, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int t;
        int at;
        int at2;
        int at3;
        int prev_count;
        int d0;
        bit abort_run;
        int abort_at;

        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        ro_in = 1'b0;
        repeat (3) next_cycle();
        check("rst_ro_en", ro_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 0);
        rst = 1'b0;
        repeat (2) next_cycle();

        // Nominal: period 10 over a 1000-cycle gate.
        hi_len = 5;
        lo_len = 5;
        pulse_start(t);
        wait_done(RUN + 50, at);
        check("nom_latency", at - t, RUN);
        check("nom_count_in_range", (count >= 99 && count <= 101), 1);
        check("nom_overflow", overflow, 0);
        check("nom_ro_en_at_done", ro_en, 0);
        prev_count = m_count;

        // Abort 500 cycles into a second run.
        next_cycle();
        pulse_start(t);
        while (cyc < t + 500) next_cycle();
        stop = 1'b1;
        next_cycle();
        stop = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_ro_en", ro_en, 0);
        d0 = dut_dones;
        repeat (RUN + 50) next_cycle();
        check("abort_no_done", dut_dones - d0, 0);
        check("abort_count_kept", count, prev_count);

        // Saturation at period 4, then a run with ro_in stuck low.
        hi_len = 2;
        lo_len = 2;
        pulse_start(t);
        wait_done(RUN + 50, at);
        check("sat_count", count, MAXC);
        check("sat_overflow", overflow, 1);
        hi_len = 0;
        lo_len = 4;
        next_cycle();
        pulse_start(t);
        wait_done(RUN + 50, at);
        check("low_count", count, 0);
        check("low_overflow", overflow, 0);

        // Reset during GATE, then a normal run.
        hi_len = 5;
        lo_len = 5;
        pulse_start(t);
        repeat (600) next_cycle();
        #2 rst = 1'b1;
        #1;
        check("midrst_ro_en", ro_en, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_count", count, 0);
        check("midrst_overflow", overflow, 0);
        next_cycle();
        rst = 1'b0;
        next_cycle();
        pulse_start(t);
        wait_done(RUN + 50, at);
        check("post_rst_latency", at - t, RUN);
        check("post_rst_count_in_range", (count >= 99 && count <= 101), 1);

        // start pulses while busy are ignored.
        next_cycle();
        d0 = dut_dones;
        pulse_start(t);
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(10, 40)) next_cycle();
            start = 1'b1;
            next_cycle();
            start = 1'b0;
        end
        wait_done(RUN + 50, at);
        repeat (30) next_cycle();
        check("one_done_per_start", dut_dones - d0, 1);

        // start and stop together in IDLE.
        start = 1'b1;
        stop  = 1'b1;
        repeat (5) next_cycle();
        check("start_stop_busy", busy, 0);
        check("start_stop_ro_en", ro_en, 0);
        start = 1'b0;
        stop  = 1'b0;
        next_cycle();

        // Back-to-back with start held high.
        hi_len = 3;
        lo_len = 6;
        start  = 1'b1;
        t      = cyc;
        wait_done(RUN + 50, at);
        check("b2b_first_latency", at - t, RUN);
        check("b2b_ro_en_at_done", ro_en, 0);
        next_cycle();
        check("b2b_ro_en_after_done", ro_en, 1);
        check("b2b_busy_after_done", busy, 1);
        wait_done(RUN + 50, at2);
        check("b2b_period_1", at2 - at, RUN);
        wait_done(RUN + 50, at3);
        check("b2b_period_2", at3 - at2, RUN);
        start = 1'b0;
        next_cycle();

        // Randomized runs: random waveform, stray starts, occasional aborts.
        for (int r = 0; r < 8; r++) begin
            hi_len    = $urandom_range(1, 15);
            lo_len    = $urandom_range(1, 15);
            abort_run = ($urandom_range(0, 3) == 0);
            abort_at  = $urandom_range(1, RUN - 1);
            repeat ($urandom_range(1, 20)) next_cycle();
            pulse_start(t);
            for (int k = 1; k < RUN + 20; k++) begin
                start = ($urandom_range(0, 15) == 0);
                stop  = abort_run && (k == abort_at);
                next_cycle();
            end
            start = 1'b0;
            stop  = 1'b0;
            wait_idle(RUN + 50);
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
